// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl download loader: region descriptor, FSM state
// encoding and the index range helper.
package ioctl_loader_pkg;

  localparam int unsigned IDX_W         = 6;
  localparam int unsigned LOADER_AW_MAX = 32;

  // Region i occupies slice [i*W +: W] of each packed region parameter.
  typedef struct packed {
    logic [IDX_W-1:0]         idx_lo;
    logic [IDX_W-1:0]         idx_hi;
    logic [LOADER_AW_MAX-1:0] base;
    logic [LOADER_AW_MAX-1:0] size;
  } loader_region_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWaitAck,
    StDone
  } loader_state_e;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] lo,
                                        input logic [IDX_W-1:0] hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational priority decode of a download index to its region number,
// SDRAM base address and byte capacity.
module ioctl_region_decode
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned       NREG       = 2,
  parameter int unsigned       AW         = 25,
  parameter int unsigned       RW         = 1,
  parameter logic [NREG*6-1:0] REG_IDX_LO = {6'h00, 6'h02},
  parameter logic [NREG*6-1:0] REG_IDX_HI = {6'h01, 6'h02},
  parameter logic [NREG*AW-1:0] REG_BASE  = {25'h0, 25'h100000},
  parameter logic [NREG*AW-1:0] REG_SIZE  = {25'h100000, 25'h8000}
) (
  input  logic [IDX_W-1:0] index_i,
  output logic             hit_o,
  output logic [RW-1:0]    region_o,
  output logic [AW-1:0]    base_o,
  output logic [AW-1:0]    size_o
);

  loader_region_t regs [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    assign regs[g] = '{
      idx_lo: REG_IDX_LO[g*IDX_W +: IDX_W],
      idx_hi: REG_IDX_HI[g*IDX_W +: IDX_W],
      base:   LOADER_AW_MAX'(REG_BASE[g*AW +: AW]),
      size:   LOADER_AW_MAX'(REG_SIZE[g*AW +: AW])
    };
  end

  // Scan downwards so the lowest matching region number is the one kept.
  always_comb begin
    hit_o    = 1'b0;
    region_o = '0;
    base_o   = '0;
    size_o   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (idx_in_range(index_i, regs[i].idx_lo, regs[i].idx_hi)) begin
        hit_o    = 1'b1;
        region_o = RW'(i);
        base_o   = AW'(regs[i].base);
        size_o   = AW'(regs[i].size);
      end
    end
  end

endmodule

// File: rtl/ioctl_loader.sv
// Packs host ioctl beats into memory words for one of NREG index ranges and
// writes them over a toggle req/ack handshake with partial-word flush.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned        IOCTL_DW   = 16,
  parameter int unsigned        MEM_DW     = 32,
  parameter int unsigned        AW         = 25,
  parameter int unsigned        NREG       = 2,
  parameter logic [NREG*6-1:0]  REG_IDX_LO = {6'h00, 6'h02},
  parameter logic [NREG*6-1:0]  REG_IDX_HI = {6'h01, 6'h02},
  parameter logic [NREG*AW-1:0] REG_BASE   = {25'h0, 25'h100000},
  parameter logic [NREG*AW-1:0] REG_SIZE   = {25'h100000, 25'h8000},
  localparam int unsigned       RW         = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_DW-1:0] ioctl_dout,
  output logic                ioctl_wait,
  output logic                mem_active,
  output logic [AW-1:0]       mem_addr,
  output logic [MEM_DW-1:0]   mem_din,
  output logic [MEM_DW/8-1:0] mem_be,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [RW-1:0]       region,
  output logic                overflow,
  output logic                done
);

  localparam int unsigned RATIO = MEM_DW / IOCTL_DW;
  localparam int unsigned BE_W  = MEM_DW / 8;
  localparam int unsigned BPL   = IOCTL_DW / 8;
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [AW-1:0] STEP    = AW'(BE_W);
  localparam logic [AW-1:0] OFS_MAX = '1;
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

  loader_state_e     state_q;
  logic [LW-1:0]     lane_q;
  logic [MEM_DW-1:0] buf_q;
  logic [BE_W-1:0]   be_q;
  logic [AW-1:0]     offset_q, base_q, size_q, addr_q;
  logic [MEM_DW-1:0] din_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [RW-1:0]     region_q;
  logic              end_q, start_prev_q, wait_q, active_q, req_q, ovf_q, done_q;

  logic              hit;
  logic [RW-1:0]     hit_region;
  logic [AW-1:0]     hit_base, hit_size;
  logic              unused_idx;

  assign unused_idx = ^ioctl_index[7:6];

  ioctl_region_decode #(
    .NREG      (NREG),
    .AW        (AW),
    .RW        (RW),
    .REG_IDX_LO(REG_IDX_LO),
    .REG_IDX_HI(REG_IDX_HI),
    .REG_BASE  (REG_BASE),
    .REG_SIZE  (REG_SIZE)
  ) u_decode (
    .index_i (ioctl_index[5:0]),
    .hit_o   (hit),
    .region_o(hit_region),
    .base_o  (hit_base),
    .size_o  (hit_size)
  );

  logic              dl_hit, start;
  logic [MEM_DW-1:0] buf_ins, word_din;
  logic [BE_W-1:0]   be_ins, word_be;
  logic              fill_full, issue;
  logic [AW-1:0]     offset_inc;

  assign dl_hit = ioctl_download & hit;
  assign start  = dl_hit & ~start_prev_q;

  always_comb begin
    buf_ins = buf_q;
    be_ins  = be_q;
    buf_ins[lane_q*IOCTL_DW +: IOCTL_DW] = ioctl_dout;
    be_ins[lane_q*BPL +: BPL]            = '1;
    word_din   = ioctl_wr ? buf_ins : buf_q;
    word_be    = ioctl_wr ? be_ins : be_q;
    fill_full  = ioctl_wr && (lane_q == LANE_LAST);
    // A falling download flushes whatever lanes hold data, including a beat
    // arriving on the same edge.
    issue      = fill_full || (!ioctl_download && (word_be != '0));
    offset_inc = (offset_q > (OFS_MAX - STEP)) ? OFS_MAX : (offset_q + STEP);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      buf_q        <= '0;
      be_q         <= '0;
      offset_q     <= '0;
      base_q       <= '0;
      size_q       <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      mem_be_q     <= '0;
      region_q     <= '0;
      end_q        <= 1'b0;
      // A download still high across reset must not look like a new start.
      start_prev_q <= dl_hit;
      wait_q       <= 1'b0;
      active_q     <= 1'b0;
      req_q        <= mem_ack;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      start_prev_q <= dl_hit;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            region_q <= hit_region;
            base_q   <= hit_base;
            size_q   <= hit_size;
            offset_q <= '0;
            lane_q   <= '0;
            be_q     <= '0;
            buf_q    <= '0;
            ovf_q    <= 1'b0;
            end_q    <= 1'b0;
            active_q <= 1'b1;
            state_q  <= StFill;
          end
        end
        StFill: begin
          if (issue) begin
            addr_q   <= base_q + offset_q;
            din_q    <= word_din;
            mem_be_q <= word_be;
            end_q    <= ~ioctl_download;
            if (offset_q < size_q) begin
              req_q   <= ~req_q;
              wait_q  <= 1'b1;
              state_q <= StWaitAck;
            end else begin
              ovf_q    <= 1'b1;
              offset_q <= offset_inc;
              lane_q   <= '0;
              be_q     <= '0;
              buf_q    <= '0;
              if (!ioctl_download) begin
                done_q   <= 1'b1;
                active_q <= 1'b0;
                state_q  <= StDone;
              end
            end
          end else if (!ioctl_download) begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= StDone;
          end else if (ioctl_wr) begin
            buf_q  <= buf_ins;
            be_q   <= be_ins;
            lane_q <= lane_q + 1'b1;
          end
        end
        StWaitAck: begin
          if (req_q == mem_ack) begin
            wait_q   <= 1'b0;
            offset_q <= offset_inc;
            lane_q   <= '0;
            be_q     <= '0;
            buf_q    <= '0;
            if (end_q || !ioctl_download) begin
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= StDone;
            end else begin
              state_q <= StFill;
            end
          end else if (!ioctl_download) begin
            end_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_active = active_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_be     = mem_be_q;
  assign mem_req    = req_q;
  assign region     = region_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Scoreboard bench for ioctl_loader: a 16/32 instance with a shrunken
// index-2 region and an 8/64 instance, each with its own memory responder.
module tb_ioctl_loader;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset;

  logic        a_dl, a_wr, a_wait, a_active, a_req, a_ack, a_ovf, a_done;
  logic [7:0]  a_idx;
  logic [15:0] a_dout;
  logic [24:0] a_addr;
  logic [31:0] a_din;
  logic [3:0]  a_be;
  logic [0:0]  a_region;

  logic        b_dl, b_wr, b_wait, b_active, b_req, b_ack, b_ovf, b_done;
  logic [7:0]  b_idx;
  logic [7:0]  b_dout;
  logic [24:0] b_addr;
  logic [63:0] b_din;
  logic [7:0]  b_be;
  logic [0:0]  b_region;

  ioctl_loader #(
    .REG_SIZE({25'h100000, 25'h8})
  ) u_dut_a (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(a_dl),
    .ioctl_index   (a_idx),
    .ioctl_wr      (a_wr),
    .ioctl_dout    (a_dout),
    .ioctl_wait    (a_wait),
    .mem_active    (a_active),
    .mem_addr      (a_addr),
    .mem_din       (a_din),
    .mem_be        (a_be),
    .mem_req       (a_req),
    .mem_ack       (a_ack),
    .region        (a_region),
    .overflow      (a_ovf),
    .done          (a_done)
  );

  ioctl_loader #(
    .IOCTL_DW(8),
    .MEM_DW  (64)
  ) u_dut_b (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(b_dl),
    .ioctl_index   (b_idx),
    .ioctl_wr      (b_wr),
    .ioctl_dout    (b_dout),
    .ioctl_wait    (b_wait),
    .mem_active    (b_active),
    .mem_addr      (b_addr),
    .mem_din       (b_din),
    .mem_be        (b_be),
    .mem_req       (b_req),
    .mem_ack       (b_ack),
    .region        (b_region),
    .overflow      (b_ovf),
    .done          (b_done)
  );

  typedef struct {
    logic [24:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t ea, eb;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  bit  a_hold   = 1'b0;
  int  a_lag = 0, b_lag = 0;
  int  a_wr_cnt = 0, b_wr_cnt = 0, a_done_cnt = 0, b_done_cnt = 0, a_act_cnt = 0;
  logic a_req_prev, b_req_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor and memory responder; outputs are sampled before ack is driven.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      check("a_wait_tracks_req", a_wait, a_req != a_ack);
      check("b_wait_tracks_req", b_wait, b_req != b_ack);
      if (a_req != a_req_prev && a_req != a_ack) begin
        a_wr_cnt++;
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_write: got addr %0h din %0h, required no write",
                   a_addr, a_din);
        end else begin
          ea = exp_a.pop_front();
          check("a_addr", a_addr, ea.addr);
          check("a_din", a_din, ea.din);
          check("a_be", a_be, ea.be);
        end
      end
      if (b_req != b_req_prev && b_req != b_ack) begin
        b_wr_cnt++;
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_write: got addr %0h din %0h, required no write",
                   b_addr, b_din);
        end else begin
          eb = exp_b.pop_front();
          check("b_addr", b_addr, eb.addr);
          check("b_din", b_din, eb.din);
          check("b_be", b_be, eb.be);
        end
      end
      if (a_done) begin
        a_done_cnt++;
        check("a_done_no_pending", a_req, a_ack);
      end
      if (b_done) b_done_cnt++;
      if (a_active) a_act_cnt++;
      if (a_req != a_ack && !a_hold) begin
        a_lag++;
        if (a_lag == 3) begin
          a_ack = a_req;
          a_lag = 0;
        end
      end else if (a_req == a_ack) begin
        a_lag = 0;
      end
      if (b_req != b_ack) begin
        b_lag++;
        if (b_lag == 3) begin
          b_ack = b_req;
          b_lag = 0;
        end
      end else begin
        b_lag = 0;
      end
    end
    a_req_prev = a_req;
    b_req_prev = b_req;
  end

  task automatic a_idle();
    int n = 0;
    while (a_wait === 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_wait_timeout: ioctl_wait 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic a_beat(input logic [15:0] d);
    a_idle();
    a_wr   = 1'b1;
    a_dout = d;
    @(negedge clk_sys);
    a_wr = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d);
    int n = 0;
    while (b_wait === 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL b_wait_timeout: ioctl_wait 1 after %0d cycles, required 0", n);
    end
    b_wr   = 1'b1;
    b_dout = d;
    @(negedge clk_sys);
    b_wr = 1'b0;
  endtask

  task automatic a_run_basic(input string tag);
    int d0;
    d0 = a_done_cnt;
    exp_a.push_back('{addr: 25'h0, din: 64'h22221111, be: 8'hF});
    exp_a.push_back('{addr: 25'h4, din: 64'h44443333, be: 8'hF});
    a_idx = 8'h01;
    a_dl  = 1'b1;
    @(negedge clk_sys);
    check({tag, "_active"}, a_active, 1'b1);
    check({tag, "_region"}, a_region, 1'b1);
    a_beat(16'h1111);
    a_beat(16'h2222);
    a_beat(16'h3333);
    a_beat(16'h4444);
    a_idle();
    a_dl = 1'b0;
    repeat (15) @(negedge clk_sys);
    check({tag, "_done_count"}, a_done_cnt - d0, 1);
    check({tag, "_active_end"}, a_active, 1'b0);
    check({tag, "_overflow"}, a_ovf, 1'b0);
    check({tag, "_sb_empty"}, exp_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, act0;
    reset = 1'b1;
    a_dl = 1'b0; a_wr = 1'b0; a_idx = '0; a_dout = '0; a_ack = 1'b0;
    b_dl = 1'b0; b_wr = 1'b0; b_idx = '0; b_dout = '0; b_ack = 1'b0;
    repeat (3) @(negedge clk_sys);

    check("rst_wait", a_wait, 1'b0);
    check("rst_active", a_active, 1'b0);
    check("rst_be", a_be, 4'h0);
    check("rst_done", a_done, 1'b0);
    check("rst_overflow", a_ovf, 1'b0);
    check("rst_region", a_region, 1'b0);
    check("rst_req_eq_ack", a_req, a_ack);
    check("rst_addr", a_addr, 25'h0);
    check("rst_din", a_din, 32'h0);
    check("rst_b_be", b_be, 8'h00);
    reset = 1'b0;
    @(negedge clk_sys);
    mon_en = 1'b1;

    // Two full words from region 1.
    a_run_basic("basic");

    // Partial word flushed when download falls after three beats.
    d0 = a_done_cnt;
    exp_a.push_back('{addr: 25'h0, din: 64'h22221111, be: 8'hF});
    exp_a.push_back('{addr: 25'h4, din: 64'h00003333, be: 8'h3});
    a_idx = 8'h01;
    a_dl  = 1'b1;
    @(negedge clk_sys);
    a_beat(16'h1111);
    a_beat(16'h2222);
    a_beat(16'h3333);
    a_dl = 1'b0;
    repeat (15) @(negedge clk_sys);
    check("partial_done_count", a_done_cnt - d0, 1);
    check("partial_sb_empty", exp_a.size(), 0);

    // Region 0 holds only 8 bytes: two writes land, four words are dropped.
    d0 = a_done_cnt;
    w0 = a_wr_cnt;
    exp_a.push_back('{addr: 25'h100000, din: 64'hA001A000, be: 8'hF});
    exp_a.push_back('{addr: 25'h100004, din: 64'hA003A002, be: 8'hF});
    a_idx = 8'h02;
    a_dl  = 1'b1;
    @(negedge clk_sys);
    check("ovf_region", a_region, 1'b0);
    for (int i = 0; i < 12; i++) a_beat(16'hA000 + 16'(i));
    a_idle();
    check("ovf_overflow_flag", a_ovf, 1'b1);
    a_dl = 1'b0;
    repeat (15) @(negedge clk_sys);
    check("ovf_write_count", a_wr_cnt - w0, 2);
    check("ovf_done_count", a_done_cnt - d0, 1);
    check("ovf_sb_empty", exp_a.size(), 0);

    // Unmatched index: the whole download is ignored.
    d0   = a_done_cnt;
    w0   = a_wr_cnt;
    act0 = a_act_cnt;
    a_idx = 8'h05;
    a_dl  = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) a_beat(16'h5550 + 16'(i));
    a_dl = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("nomatch_active_cycles", a_act_cnt - act0, 0);
    check("nomatch_write_count", a_wr_cnt - w0, 0);
    check("nomatch_done_count", a_done_cnt - d0, 0);
    check("nomatch_wait", a_wait, 1'b0);

    // Reset while a write is outstanding and ack is held back.
    d0     = a_done_cnt;
    a_hold = 1'b1;
    exp_a.push_back('{addr: 25'h0, din: 64'h22221111, be: 8'hF});
    a_idx = 8'h01;
    a_dl  = 1'b1;
    @(negedge clk_sys);
    a_beat(16'h1111);
    a_beat(16'h2222);
    repeat (2) @(negedge clk_sys);
    check("abort_wait_before", a_wait, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("abort_wait", a_wait, 1'b0);
    check("abort_active", a_active, 1'b0);
    check("abort_req_eq_ack", a_req, a_ack);
    reset  = 1'b0;
    a_dl   = 1'b0;
    a_hold = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("abort_done_count", a_done_cnt - d0, 0);
    check("abort_sb_empty", exp_a.size(), 0);
    a_run_basic("after_abort");

    // 8-bit beats into a 64-bit word.
    d0 = b_done_cnt;
    w0 = b_wr_cnt;
    exp_b.push_back('{addr: 25'h0, din: 64'h0807060504030201, be: 8'hFF});
    b_idx = 8'h01;
    b_dl  = 1'b1;
    @(negedge clk_sys);
    for (int i = 1; i <= 8; i++) b_beat(8'(i));
    repeat (8) @(negedge clk_sys);
    b_dl = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("wide_write_count", b_wr_cnt - w0, 1);
    check("wide_done_count", b_done_cnt - d0, 1);
    check("wide_sb_empty", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
